uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART transmit FIFO write port among NumReq byte-stream requesters, e.g. CPU bus write path, debug monitor and boot loader.
- A grant is held for a whole packet, up to MaxBurst bytes, so that bytes from different requesters do not interleave on txd.
- The block sits between the requesters and the transmit FIFO write port, wr_en/wr_data/full, of the UART controller.

Parameters:
- NumReq, 4, number of requesters; must be 2..8.
- DataWidth, 8, byte width; equals the UART data width.
- MaxBurst, 16, maximum bytes per grant before a forced release; must be at least 1.
- StallLimit, 64, consecutive idle cycles of a granted requester before a forced release; must be at least 1.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  NumReq  per-requester byte valid
- req_last_i  in  NumReq  per-requester end-of-packet flag, qualified by valid
- req_data_i  in  NumReq*DataWidth  packed bytes; requester k occupies bits [k*DataWidth +: DataWidth]
- req_ready_o  out  NumReq  per-requester byte accepted
- fifo_full_i  in  1  transmit FIFO full
- fifo_wr_en_o  out  1  transmit FIFO write strobe
- fifo_wr_data_o  out  DataWidth  transmit FIFO write byte
- grant_id_o  out  $clog2(NumReq)  current owner; valid only while busy_o is high
- busy_o  out  1  a grant is held
- stall_release_o  out  1  one-cycle pulse when a grant is dropped on stall timeout

Behaviour:
- Reset (rst_ni low, asynchronous) forces:
  - state = IDLE, rr_ptr = 0, burst_cnt = 0, stall_cnt = 0;
  - every output to 0.
- Clock and reset are one clock domain, clk_i, with asynchronous active-low reset rst_ni. No internal clock gating.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - Search req_valid_i starting at index rr_ptr and wrapping modulo NumReq; the first set bit wins.
  - If a winner exists: grant_id <= winner, state <= GRANT, burst_cnt <= 0, stall_cnt <= 0.
  - One arbitration cycle is spent; no byte is accepted in IDLE. All req_ready_o bits are 0.
- GRANT, with g = grant_id:
  - req_ready_o[g] = ~fifo_full_i; all other ready bits are 0.
  - xfer = req_valid_i[g] & ~fifo_full_i.
  - fifo_wr_en_o = xfer, combinational, same cycle.
  - fifo_wr_data_o = req_data_i[g]. Output 0 when not in GRANT.
- On xfer, burst_cnt increments and stall_cnt is cleared.
  - If req_last_i[g] is set, or burst_cnt+1 == MaxBurst: release.
- Stall counting: if req_valid_i[g] is low, stall_cnt increments.
  - If stall_cnt reaches StallLimit-1: release and pulse stall_release_o for one cycle.
- A full FIFO with valid high is backpressure, not a stall. stall_cnt holds and burst_cnt holds.
- Release: state <= IDLE, rr_ptr <= (g+1) mod NumReq, wrapping from NumReq-1 to 0.
  - rr_ptr only updates on release, so the same requester cannot win twice in a row while others are waiting.
- busy_o = (state == GRANT). A release takes effect at the clock edge; busy_o falls the next cycle.
- Back-to-back packets cost one IDLE cycle each: minimum 1 bubble per grant.
- Simultaneous last and burst limit: one release, not two.
  - Last on the MaxBurst-th byte: normal release, no stall pulse.
- A requester that drops valid mid-packet keeps the grant until its last byte, the burst limit, or the stall timeout.
- Asserting reset mid-packet aborts immediately.
  - The partially sent packet is not resumed.
  - After reset, arbitration restarts from index 0.
- Counters are sized $clog2(MaxBurst+1) and $clog2(StallLimit+1) bits. Neither counter wraps; each is cleared on release.

Test Plan:
- Single requester 1 sends 3 bytes 0x41,0x42,0x43, last on 0x43, FIFO never full → 1 IDLE cycle, then 3 consecutive fifo_wr_en_o pulses with the bytes in order; busy_o drops; rr_ptr = 2.
- Requesters 0 and 2 both valid from reset, each a 2-byte packet → order is 0, 0, 2, 2. Grant_id sequence is 0 then 2, with one idle bubble between grants.
- MaxBurst = 4; requester 3 streams 6 bytes with no last, requester 0 waiting → 4 bytes from 3, then 0 is granted, then 3 resumes with its remaining 2 bytes.
- fifo_full_i held high for 10 cycles mid-packet → req_ready_o[g] = 0 and no write; stall_release_o never pulses; the packet completes after full deasserts.
- Granted requester drops valid for StallLimit cycles → release at cycle StallLimit with a 1-cycle stall_release_o pulse; the next valid requester is granted.
- rst_ni pulsed low mid-packet → all outputs 0 immediately (asynchronously); after release of reset, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit FIFO write port among NumReq
// byte-stream requesters; a grant is held for a whole packet (bounded by MaxBurst).
module uart_tx_arbiter #(
    parameter int NumReq     = 4,
    parameter int DataWidth  = 8,
    parameter int MaxBurst   = 16,
    parameter int StallLimit = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq-1:0]             req_last_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DataWidth-1:0]          fifo_wr_data_o,
    output logic [$clog2(NumReq)-1:0]     grant_id_o,
    output logic                          busy_o,
    output logic                          stall_release_o
);

    localparam int IdW    = $clog2(NumReq);
    localparam int ScanW  = IdW + 1;
    localparam int BurstW = $clog2(MaxBurst + 1);
    localparam int StallW = $clog2(StallLimit + 1);

    localparam logic [BurstW-1:0] BurstLast = BurstW'(MaxBurst);
    localparam logic [StallW-1:0] StallLast = StallW'(StallLimit - 1);
    localparam logic [IdW-1:0]    IdTop     = IdW'(NumReq - 1);
    localparam logic [ScanW-1:0]  ScanWrap  = ScanW'(NumReq);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e              state_r, state_s;
    logic [IdW-1:0]      grant_r, grant_s;
    logic [IdW-1:0]      rr_ptr_r, rr_ptr_s;
    logic [BurstW-1:0]   burst_cnt_r, burst_cnt_s;
    logic [StallW-1:0]   stall_cnt_r, stall_cnt_s;

    logic [IdW-1:0]      winner_s;
    logic                found_s;
    logic [ScanW-1:0]    scan_idx_s;

    logic                granted_s;
    logic                g_valid_s;
    logic                g_last_s;
    logic [DataWidth-1:0] g_data_s;
    logic                xfer_s;
    logic                burst_hit_s;
    logic                stall_hit_s;
    logic                release_s;
    logic [IdW-1:0]      next_ptr_s;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        winner_s   = '0;
        found_s    = 1'b0;
        scan_idx_s = '0;
        for (int i = 0; i < NumReq; i++) begin
            scan_idx_s = {1'b0, rr_ptr_r} + ScanW'(i);
            if (scan_idx_s >= ScanWrap) begin
                scan_idx_s = scan_idx_s - ScanWrap;
            end else begin
                scan_idx_s = scan_idx_s;
            end
            if (!found_s && req_valid_i[scan_idx_s[IdW-1:0]]) begin
                found_s  = 1'b1;
                winner_s = scan_idx_s[IdW-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Owner's handshake view and the release conditions.
    always_comb begin
        granted_s   = (state_r == GRANT);
        g_valid_s   = req_valid_i[grant_r];
        g_last_s    = req_last_i[grant_r];
        g_data_s    = req_data_i[int'(grant_r) * DataWidth +: DataWidth];
        xfer_s      = granted_s & g_valid_s & ~fifo_full_i;
        burst_hit_s = ((burst_cnt_r + BurstW'(1)) == BurstLast);
        // A full FIFO with valid high is backpressure; only a missing valid counts as stall.
        stall_hit_s = granted_s & ~g_valid_s & (stall_cnt_r == StallLast);
        release_s   = (xfer_s & (g_last_s | burst_hit_s)) | stall_hit_s;
        if (grant_r == IdTop) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_r + IdW'(1);
        end
    end

    // Next-state logic for the IDLE/GRANT machine and its counters.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        rr_ptr_s    = rr_ptr_r;
        burst_cnt_s = burst_cnt_r;
        stall_cnt_s = stall_cnt_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s     = GRANT;
                    grant_s     = winner_s;
                    burst_cnt_s = '0;
                    stall_cnt_s = '0;
                end else begin
                    state_s     = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_s     = IDLE;
                    rr_ptr_s    = next_ptr_s;
                    burst_cnt_s = '0;
                    stall_cnt_s = '0;
                end else if (xfer_s) begin
                    burst_cnt_s = burst_cnt_r + BurstW'(1);
                    stall_cnt_s = '0;
                end else if (!g_valid_s) begin
                    stall_cnt_s = stall_cnt_r + StallW'(1);
                end else begin
                    stall_cnt_s = stall_cnt_r;
                end
            end
            default: begin
                state_s     = IDLE;
                burst_cnt_s = '0;
                stall_cnt_s = '0;
            end
        endcase
    end

    // Output decode; everything is quiet outside GRANT.
    always_comb begin
        req_ready_o     = '0;
        fifo_wr_en_o    = xfer_s;
        fifo_wr_data_o  = '0;
        grant_id_o      = '0;
        busy_o          = granted_s;
        stall_release_o = stall_hit_s;
        if (granted_s) begin
            req_ready_o[grant_r] = ~fifo_full_i;
            fifo_wr_data_o       = g_data_s;
            grant_id_o           = grant_r;
        end else begin
            req_ready_o          = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            rr_ptr_r    <= '0;
            burst_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            rr_ptr_r    <= rr_ptr_s;
            burst_cnt_r <= burst_cnt_s;
            stall_cnt_r <= stall_cnt_s;
        end
    end

endmodule
